// File: rtl/pa_fpu_frbus_arb_pkg.sv
// FPU result-forwarding bus shared definitions.
// Default widths, source indices and fflag bit positions.
package pa_fpu_frbus_arb_pkg;

    localparam int FRB_DATA_W  = 32;
    localparam int FRB_FFLAG_W = 5;

    localparam int SRC_DIV = 0;
    localparam int SRC_EX2 = 1;
    localparam int SRC_CVT = 2;
    localparam int SRC_FMA = 3;

    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

endpackage

// File: rtl/pa_fpu_rr_arb.sv
// Request/grant arbiter, fixed priority or round-robin.
// Ports: clk/rst_b, i_req, i_en (grant allowed), o_gnt, o_gnt_idx, o_any.
module pa_fpu_rr_arb #(
    parameter int NUM_SRC  = 4,
    parameter int SRC_ID_W = 2,
    parameter int RR_MODE  = 1
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic [NUM_SRC-1:0]  i_req,
    input  logic                i_en,
    output logic [NUM_SRC-1:0]  o_gnt,
    output logic [SRC_ID_W-1:0] o_gnt_idx,
    output logic                o_any
);

    logic [SRC_ID_W-1:0] r_ptr;
    logic [SRC_ID_W-1:0] w_idx;
    logic [SRC_ID_W-1:0] w_nxt;
    logic [NUM_SRC-1:0]  w_gnt;
    logic                w_found;
    int                  w_base;
    int                  w_j;

    // Search begins at the pointer (or 0 in fixed mode) and wraps.
    always_comb begin
        w_gnt   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        w_base  = (RR_MODE != 0) ? int'(r_ptr) : 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_j = w_base + k;
            if (w_j >= NUM_SRC)
                w_j = w_j - NUM_SRC;
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                w_gnt[w_j] = 1'b1;
                w_idx      = SRC_ID_W'(w_j);
            end
        end
    end

    assign w_nxt = (w_idx == SRC_ID_W'(NUM_SRC - 1)) ?
                   '0 : w_idx + SRC_ID_W'(1);

    assign o_gnt     = i_en ? w_gnt : '0;
    assign o_gnt_idx = w_idx;
    assign o_any     = i_en & w_found;

    always_ff @(posedge clk) begin
        if (!rst_b)
            r_ptr <= '0;
        else if (o_any)
            r_ptr <= w_nxt;
    end

endmodule

// File: rtl/pa_fpu_frbus_arb.sv
// FPU result-forwarding bus: arbitrates sources onto one output register.
// Ports: per-source vld/rdy/data/fflags, flush/clr, IDU fwd handshake, acc.
module pa_fpu_frbus_arb
    import pa_fpu_frbus_arb_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int DATA_WIDTH  = FRB_DATA_W,
    parameter int FFLAG_WIDTH = FRB_FFLAG_W,
    parameter int SRC_ID_W    = 2,
    parameter int RR_MODE     = 1
) (
    input  logic                           cpuclk,
    input  logic                           cpurst_b,
    input  logic [NUM_SRC-1:0]             frbus_src_vld,
    output logic [NUM_SRC-1:0]             frbus_src_rdy,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]  frbus_src_data,
    input  logic [NUM_SRC*FFLAG_WIDTH-1:0] frbus_src_fflags,
    input  logic                           ctrl_frbus_flush,
    input  logic                           ctrl_frbus_fflags_clr,
    input  logic                           idu_fpu_fwd_rdy,
    output logic                           fpu_idu_fwd_vld,
    output logic [DATA_WIDTH-1:0]          fpu_idu_fwd_data,
    output logic [FFLAG_WIDTH-1:0]         fpu_idu_fwd_fflags,
    output logic [SRC_ID_W-1:0]            fpu_idu_fwd_src,
    output logic [FFLAG_WIDTH-1:0]         fpu_frbus_fflags_acc
);

    logic                   r_vld;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [FFLAG_WIDTH-1:0] r_fflags;
    logic [SRC_ID_W-1:0]    r_src;
    logic [FFLAG_WIDTH-1:0] r_acc;

    logic                   w_load;
    logic                   w_any;
    logic                   w_deliver;
    logic [NUM_SRC-1:0]     w_gnt;
    logic [SRC_ID_W-1:0]    w_idx;
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic [FFLAG_WIDTH-1:0] w_sel_ff;

    // Reset is folded in so no source sees an accept while held in reset.
    assign w_load = cpurst_b & ~ctrl_frbus_flush &
                    (~r_vld | idu_fpu_fwd_rdy);

    assign w_deliver = r_vld & idu_fpu_fwd_rdy & ~ctrl_frbus_flush;

    pa_fpu_rr_arb #(
        .NUM_SRC  (NUM_SRC),
        .SRC_ID_W (SRC_ID_W),
        .RR_MODE  (RR_MODE)
    ) u_arb (
        .clk       (cpuclk),
        .rst_b     (cpurst_b),
        .i_req     (frbus_src_vld),
        .i_en      (w_load),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_idx),
        .o_any     (w_any)
    );

    assign frbus_src_rdy = w_gnt;

    assign w_sel_data =
        frbus_src_data[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_ff =
        frbus_src_fflags[int'(w_idx)*FFLAG_WIDTH +: FFLAG_WIDTH];

    always_ff @(posedge cpuclk) begin
        if (!cpurst_b) begin
            r_vld    <= 1'b0;
            r_data   <= '0;
            r_fflags <= '0;
            r_src    <= '0;
        end else if (ctrl_frbus_flush) begin
            r_vld <= 1'b0;
        end else if (w_load) begin
            r_vld <= w_any;
            if (w_any) begin
                r_data   <= w_sel_data;
                r_fflags <= w_sel_ff;
                r_src    <= w_idx;
            end
        end
    end

    // Clear takes effect before a same-cycle delivery is merged in.
    always_ff @(posedge cpuclk) begin
        if (!cpurst_b)
            r_acc <= '0;
        else if (ctrl_frbus_fflags_clr)
            r_acc <= w_deliver ? r_fflags : '0;
        else if (w_deliver)
            r_acc <= r_acc | r_fflags;
    end

    assign fpu_idu_fwd_vld      = r_vld;
    assign fpu_idu_fwd_data     = r_data;
    assign fpu_idu_fwd_fflags   = r_fflags;
    assign fpu_idu_fwd_src      = r_src;
    assign fpu_frbus_fflags_acc = r_acc;

    // A source may only withdraw its request after being accepted.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_chk
        a_src_hold: assert property (
            @(posedge cpuclk) disable iff (!cpurst_b)
            (frbus_src_vld[i] && !frbus_src_rdy[i]) |=> frbus_src_vld[i]
        );
    end

endmodule

// File: tb/tb_pa_fpu_frbus_arb.sv
// Directed self-checking bench for pa_fpu_frbus_arb.
// Instance u_rr uses round-robin; u_fp uses fixed priority.
module tb_pa_fpu_frbus_arb;
    import pa_fpu_frbus_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int FW = 5;
    localparam int SW = 2;

    localparam logic [DW-1:0] D0 = 32'h1000_0000;
    localparam logic [DW-1:0] D1 = 32'h3F80_0000;
    localparam logic [DW-1:0] D2 = 32'h2000_0002;
    localparam logic [DW-1:0] D3 = 32'h3000_0003;

    logic          clk;
    logic          rst_b;
    logic [N-1:0]  vld;
    logic [N-1:0]  srdy;
    logic [N*DW-1:0] data;
    logic [N*FW-1:0] ff;
    logic          flush;
    logic          clr;
    logic          rdy;
    logic          o_vld;
    logic [DW-1:0] o_data;
    logic [FW-1:0] o_ff;
    logic [SW-1:0] o_src;
    logic [FW-1:0] o_acc;

    logic [N-1:0]    f_vld;
    logic [N-1:0]    f_srdy;
    logic [N*DW-1:0] f_data;
    logic [N*FW-1:0] f_ff;
    logic            f_flush;
    logic            f_clr;
    logic            f_rdy;
    logic            f_o_vld;
    logic [DW-1:0]   f_o_data;
    logic [FW-1:0]   f_o_ff;
    logic [SW-1:0]   f_o_src;
    logic [FW-1:0]   f_o_acc;

    int n_chk;
    int n_err;

    pa_fpu_frbus_arb #(.NUM_SRC(N), .RR_MODE(1)) u_rr (
        .cpuclk                (clk),
        .cpurst_b              (rst_b),
        .frbus_src_vld         (vld),
        .frbus_src_rdy         (srdy),
        .frbus_src_data        (data),
        .frbus_src_fflags      (ff),
        .ctrl_frbus_flush      (flush),
        .ctrl_frbus_fflags_clr (clr),
        .idu_fpu_fwd_rdy       (rdy),
        .fpu_idu_fwd_vld       (o_vld),
        .fpu_idu_fwd_data      (o_data),
        .fpu_idu_fwd_fflags    (o_ff),
        .fpu_idu_fwd_src       (o_src),
        .fpu_frbus_fflags_acc  (o_acc)
    );

    pa_fpu_frbus_arb #(.NUM_SRC(N), .RR_MODE(0)) u_fp (
        .cpuclk                (clk),
        .cpurst_b              (rst_b),
        .frbus_src_vld         (f_vld),
        .frbus_src_rdy         (f_srdy),
        .frbus_src_data        (f_data),
        .frbus_src_fflags      (f_ff),
        .ctrl_frbus_flush      (f_flush),
        .ctrl_frbus_fflags_clr (f_clr),
        .idu_fpu_fwd_rdy       (f_rdy),
        .fpu_idu_fwd_vld       (f_o_vld),
        .fpu_idu_fwd_data      (f_o_data),
        .fpu_idu_fwd_fflags    (f_o_ff),
        .fpu_idu_fwd_src       (f_o_src),
        .fpu_frbus_fflags_acc  (f_o_acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_src [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};

    initial begin
        n_chk   = 0;
        n_err   = 0;
        rst_b   = 1'b0;
        vld     = '0;
        flush   = 1'b0;
        clr     = 1'b0;
        rdy     = 1'b0;
        data    = {D3, D2, D1, D0};
        ff      = {5'b01000, 5'b00100, 5'b00001, 5'b00000};
        f_vld   = 4'b1111;
        f_data  = {D3, D2, D1, D0};
        f_ff    = '0;
        f_flush = 1'b0;
        f_clr   = 1'b0;
        f_rdy   = 1'b1;
        tick();
        tick();

        rst_b = 1'b1;
        #1;
        chk("rst_vld", 32'(o_vld), 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_ff", 32'(o_ff), 32'd0);
        chk("rst_src", 32'(o_src), 32'd0);
        chk("rst_acc", 32'(o_acc), 32'd0);
        chk("rst_srdy", 32'(srdy), 32'd0);

        vld = 4'b0010;
        rdy = 1'b1;
        #1;
        chk("t1_srdy", 32'(srdy), 32'b0010);
        tick();
        vld = 4'b0000;
        #1;
        chk("t1_vld", 32'(o_vld), 32'd1);
        chk("t1_data", o_data, D1);
        chk("t1_src", 32'(o_src), 32'd1);
        chk("t1_ff", 32'(o_ff), 32'b00001);
        tick();
        chk("t1_acc", 32'(o_acc), 32'b00001);
        chk("t1_vld0", 32'(o_vld), 32'd0);

        vld = 4'b0100;
        rdy = 1'b0;
        #1;
        chk("bp_gnt2", 32'(srdy), 32'b0100);
        tick();
        vld = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_vld", 32'(o_vld), 32'd1);
            chk("bp_src", 32'(o_src), 32'd2);
            chk("bp_data", o_data, D2);
            chk("bp_srdy", 32'(srdy), 32'd0);
            tick();
        end
        rdy = 1'b1;
        #1;
        chk("bp_rel_srdy", 32'(srdy), 32'b0001);
        tick();
        vld = 4'b0000;
        #1;
        chk("bp_src0", 32'(o_src), 32'd0);
        chk("bp_data0", o_data, D0);
        chk("bp_acc", 32'(o_acc), 32'b00101);

        vld = 4'b1000;
        tick();
        vld = 4'b0000;
        clr = 1'b1;
        #1;
        chk("clr_pre", 32'(o_acc), 32'b00101);
        chk("clr_ff3", 32'(o_ff), 32'b01000);
        tick();
        clr = 1'b0;
        #1;
        chk("clr_dlv", 32'(o_acc), 32'b01000);
        chk("clr_vld", 32'(o_vld), 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        chk("clr_only", 32'(o_acc), 32'd0);

        vld = 4'b1111;
        #1;
        chk("rr_srdy0", 32'(srdy), 32'b0001);
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("rr_vld%0d", k), 32'(o_vld), 32'd1);
            chk($sformatf("rr_src%0d", k), 32'(o_src),
                32'(exp_src[k]));
            chk($sformatf("fp_src%0d", k), 32'(f_o_src), 32'd0);
            chk($sformatf("fp_srdy%0d", k), 32'(f_srdy), 32'b0001);
            if (k >= 5)
                vld[exp_src[k]] = 1'b0;
        end
        tick();
        chk("rr_done", 32'(o_vld), 32'd0);
        chk("rr_acc", 32'(o_acc), 32'b01101);

        ff[SRC_DIV*FW +: FW] = 5'b10000;
        vld = 4'b0001;
        #1;
        chk("fl_wrap", 32'(srdy), 32'b0001);
        tick();
        chk("fl_ff", 32'(o_ff), 32'b10000);
        flush = 1'b1;
        vld = 4'b0010;
        #1;
        chk("fl_srdy", 32'(srdy), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_vld", 32'(o_vld), 32'd0);
        chk("fl_acc", 32'(o_acc), 32'b01101);
        chk("fl_post", 32'(srdy), 32'b0010);
        tick();
        chk("fl_src1", 32'(o_src), 32'd1);

        rdy = 1'b0;
        vld = 4'b0101;
        #1;
        chk("rs_hold", 32'(srdy), 32'd0);
        tick();
        chk("rs_held", 32'(o_src), 32'd1);
        rst_b = 1'b0;
        #1;
        chk("rs_srdy", 32'(srdy), 32'd0);
        tick();
        chk("rs_vld", 32'(o_vld), 32'd0);
        chk("rs_data", o_data, 32'd0);
        chk("rs_src", 32'(o_src), 32'd0);
        chk("rs_acc", 32'(o_acc), 32'd0);
        tick();
        rst_b = 1'b1;
        rdy = 1'b1;
        #1;
        chk("rs_ptr", 32'(srdy), 32'b0001);
        tick();
        vld = 4'b0100;
        #1;
        chk("rs_src0", 32'(o_src), 32'd0);
        chk("rs_data0", o_data, D0);
        tick();
        vld = 4'b0000;
        #1;
        chk("rs_src2", 32'(o_src), 32'd2);
        tick();
        chk("end_vld", 32'(o_vld), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pa_fpu_frbus_arb.md
Name: pa_fpu_frbus_arb

Overview:
Parametrised successor of the FPU result-forwarding bus. It arbitrates among NUM_SRC FPU result producers (DIV/SQRT, EX2 datapath, future CVT/FMA pipes) and registers the winning result onto the IDU forwarding bus with a valid/ready handshake. It also keeps a sticky accumulated fflags register. It sits between the FPU execution units and the IDU/regfile writeback.

Parameters:
NUM_SRC, 4, number of result sources (2..8)
DATA_WIDTH, 32, result data width
FFLAG_WIDTH, 5, exception-flag width
SRC_ID_W, 2, width of source index (clog2(NUM_SRC))
RR_MODE, 1, 0 = fixed priority (index 0 highest), 1 = round-robin

Ports:
cpuclk  in  1  clock
cpurst_b  in  1  synchronous active-low reset
frbus_src_vld  in  NUM_SRC  per-source result valid
frbus_src_rdy  out  NUM_SRC  per-source accept (one-hot or zero)
frbus_src_data  in  NUM_SRC*DATA_WIDTH  flattened source data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
frbus_src_fflags  in  NUM_SRC*FFLAG_WIDTH  flattened source fflags
ctrl_frbus_flush  in  1  discard pending output, block grants this cycle
ctrl_frbus_fflags_clr  in  1  clear sticky fflags
idu_fpu_fwd_rdy  in  1  downstream accept
fpu_idu_fwd_vld  out  1  registered result valid
fpu_idu_fwd_data  out  DATA_WIDTH  registered result data
fpu_idu_fwd_fflags  out  FFLAG_WIDTH  registered result fflags
fpu_idu_fwd_src  out  SRC_ID_W  index of the producing source
fpu_frbus_fflags_acc  out  FFLAG_WIDTH  sticky OR of delivered fflags

Behaviour:
- Reset: the sync active-low reset is sampled on the cpuclk rising edge. When cpurst_b=0: fwd_vld=0, fwd_data=0, fwd_fflags=0, fwd_src=0, fflags_acc=0, RR pointer=0, frbus_src_rdy=0. Reset mid-transfer drops the held result silently.
- Output stage is a single register. Load enable: load = !flush & (!fwd_vld | idu_fpu_fwd_rdy).
- Grant: when load=1 and any src_vld=1, exactly one grant bit is set, and frbus_src_rdy = grant. Otherwise frbus_src_rdy=0. frbus_src_rdy is combinational from src_vld, the pointer and load, and does not depend on the same-cycle src data.
- A source transfers when src_vld[i] & src_rdy[i]. Its data, fflags and index are registered the next cycle with fwd_vld=1. Latency is 1 cycle. Back-to-back transfers run at full throughput while idu_fpu_fwd_rdy=1.
- Output hold: when fwd_vld=1 and rdy=0, all fwd_* outputs are stable and no grant is issued.
- Output clear: fwd_vld clears when it is consumed with no new grant, or on flush. The data/fflags/src registers keep their last value when fwd_vld=0; they do not need to be zeroed.
- Fixed priority (RR_MODE=0): the lowest set index wins.
- Round-robin (RR_MODE=1): search starts at the pointer and wraps modulo NUM_SRC. After a grant to index g, pointer = (g+1) mod NUM_SRC, with wrap from NUM_SRC-1 to 0. The pointer is unchanged with no grant. Any continuously valid source is granted within NUM_SRC grants.
- Flush: fwd_vld<=0 next cycle and no grant in the flush cycle. Flush overrides a simultaneous rdy. A held result is not delivered and not accumulated.
- Sticky fflags: on delivery (fwd_vld & idu_fpu_fwd_rdy & !flush), fflags_acc <= fflags_acc | fwd_fflags.
  - clr alone: acc <= 0.
  - clr with a delivery in the same cycle: acc <= fwd_fflags (clear first, then accumulate).
- Sources must hold vld/data stable until accepted. A drop of src_vld without a handshake is a protocol error (assertion).

Decomposition:
- Shared package/header: DATA_WIDTH/FFLAG_WIDTH defaults, source index constants (SRC_DIV=0, SRC_EX2=1, SRC_CVT=2, SRC_FMA=3), fflag bit positions (NV=4, DZ=3, OF=2, UF=1, NX=0).
- One sub-module: pa_fpu_rr_arb (NUM_SRC-wide request/grant with RR_MODE select, pointer register, advance input). The top holds the output register, flush logic and sticky fflags.

Test Plan:
- Reset release, all src_vld=0: all outputs 0 and src_rdy=0. Then src_vld=4'b0010 with data 0x3F800000, fflags 5'b00001 and rdy=1 -> next cycle fwd_vld=1, data=0x3F800000, src=1, then acc=5'b00001.
- Backpressure: result held with rdy=0 for 3 cycles while src0 is valid -> fwd_* stable, src_rdy=0. When rdy=1, src0 is granted that cycle and appears in the following cycle.
- Round-robin, all four sources continuously valid, rdy=1 -> fwd_src sequence 0,1,2,3,0,1. With RR_MODE=0 -> 0,0,0,...
- Flush with fwd_vld=1, fflags=5'b10000, rdy=1 -> fwd_vld=0 next cycle, acc unchanged, no src_rdy in the flush cycle.
- acc=5'b00101, then clr in the same cycle as delivery of fflags 5'b01000 -> acc=5'b01000. Clr alone -> acc=0.
- Assert cpurst_b=0 while a result is held and sources are valid -> next cycle all outputs are 0 and the pointer restarts, so the first grant after release goes to index 0.
